// File: rtl/irq_line_scheduler.sv
// Raster interrupt scheduler: NCH scanline-tick channels routed to NMI/IRQ with mask, W1C ack
// and readable status, plus the instruction ROM bank latch. All state moves on the CPU falling edge.
module irq_line_scheduler #(
  parameter int unsigned      NCH       = 3,
  parameter int unsigned      TICK_LB   = 4,
  parameter logic [8*NCH-1:0] DEF_PER   = {8'd31, 8'd15, 8'd0},
  parameter logic [NCH-1:0]   ROUTE     = 3'b001,
  parameter logic [15:0]      MASK_ADDR = 16'hE044,
  parameter logic [15:0]      ACK_ADDR  = 16'hE045,
  parameter logic [15:0]      PER_BASE  = 16'hE048,
  parameter logic [15:0]      BANK_ADDR = 16'hF000,
  parameter int unsigned      BANK_W    = 3,
  parameter int unsigned      BANK_LSB  = 5
) (
  input  logic              CPUCL,
  input  logic              RESET,
  input  logic [8:0]        PV,
  input  logic [15:0]       CPUAD,
  input  logic [7:0]        CPUWD,
  input  logic              CPUWE,
  input  logic              CPURE,
  output logic              cpu_nmi,
  output logic              cpu_irq,
  output logic [BANK_W-1:0] ROMBK,
  output logic              STATDV,
  output logic [7:0]        STATDT
);

  typedef enum logic {StSync, StRun} state_e;

  state_e                 state_q, state_d;
  logic [8:0]             ppv_q;
  logic [NCH-1:0]         mask_q, mask_d;
  logic [NCH-1:0]         pending_q, pending_d;
  logic [NCH-1:0][7:0]    period_q, period_d;
  logic [NCH-1:0][7:0]    cnt_q, cnt_d;
  logic [BANK_W-1:0]      bank_q, bank_d;
  logic                   nmi_q, irq_q;

  logic                   line_evt, load, tick;
  logic                   mask_we, ack_we, bank_we;
  logic [NCH-1:0]         fire;

  always_comb begin
    line_evt = (ppv_q != PV) && (PV[TICK_LB-1:0] == '0);
    mask_we  = CPUWE && (CPUAD == MASK_ADDR);
    ack_we   = CPUWE && (CPUAD == ACK_ADDR);
    bank_we  = CPUWE && (CPUAD == BANK_ADDR);

    // Frame alignment: the first PV==0 line after reset only arms the counters.
    load    = line_evt && (state_q == StSync) && (PV == '0);
    tick    = line_evt && (state_q == StRun);
    state_d = load ? StRun : state_q;

    mask_d   = mask_we ? CPUWD[NCH-1:0] : mask_q;
    bank_d   = bank_we ? CPUWD[BANK_LSB +: BANK_W] : bank_q;
    fire     = '0;
    cnt_d    = cnt_q;
    period_d = period_q;

    for (int unsigned c = 0; c < NCH; c++) begin
      if (load) begin
        cnt_d[c] = period_q[c];
      end else if (tick) begin
        if (cnt_q[c] == 8'd0) begin
          fire[c]  = 1'b1;
          cnt_d[c] = period_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] - 8'd1;
        end
      end
      if (CPUWE && (CPUAD == PER_BASE + 16'(c))) begin
        period_d[c] = CPUWD;
      end
    end

    // Ack clears first, then the mask gates, then a same-edge fire wins over the ack.
    pending_d = pending_q;
    if (ack_we) begin
      pending_d = pending_d & ~CPUWD[NCH-1:0];
    end
    pending_d = (pending_d & mask_d) | (fire & mask_d);
  end

  always_ff @(negedge CPUCL or posedge RESET) begin
    if (RESET) begin
      state_q   <= StSync;
      ppv_q     <= 9'h1FF;
      mask_q    <= '0;
      pending_q <= '0;
      period_q  <= DEF_PER;
      cnt_q     <= '0;
      bank_q    <= '0;
      nmi_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ppv_q     <= PV;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      nmi_q     <= |(pending_d & ROUTE);
      irq_q     <= |(pending_d & ~ROUTE);
    end
  end

  assign cpu_nmi = nmi_q;
  assign cpu_irq = irq_q;
  assign ROMBK   = bank_q;
  assign STATDV  = CPURE && (CPUAD == ACK_ADDR);
  assign STATDT  = 8'(pending_q);

endmodule
